// File: rtl/dtree_stream_wrapper.sv
// Serial-to-parallel wrapper around a combinational decision tree: packs features into feat_bus,
// samples the class after TREE_LAT settle cycles, returns it over valid/ready. Macro: DTREE_CLASS_HIST_EN.
module dtree_stream_wrapper #(
  parameter int N_FEAT   = 36,
  parameter int FEAT_W   = 8,
  parameter int CLASS_W  = 5,
  parameter int N_CLASS  = 16,
  parameter int TREE_LAT = 0,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [FEAT_W-1:0]         in_data,
  input  logic                      in_last,
  output logic [N_FEAT*FEAT_W-1:0]  feat_bus,
  input  logic [CLASS_W-1:0]        tree_class,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CLASS_W-1:0]        out_class,
  output logic                      out_err,
  output logic [CNT_W-1:0]          sample_cnt,
  output logic [1:0]                dbg_state
`ifdef DTREE_CLASS_HIST_EN
  ,
  input  logic [CLASS_W-1:0]        hist_idx,
  output logic [CNT_W-1:0]          hist_cnt
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1; in_ready and
  // out_valid are decoded from registered state only, so neither depends combinationally on its peer.
  localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam logic [CLASS_W:0] LP_N_CLASS = (CLASS_W+1)'(N_CLASS);

  typedef enum logic [1:0] {ST_LOAD = 2'd0, ST_EVAL = 2'd1, ST_OUT = 2'd2} state_t;

  state_t                     r_state, w_next;
  logic [IDX_W-1:0]           r_idx;
  logic [7:0]                 r_wait;
  logic                       r_err;
  logic [N_FEAT*FEAT_W-1:0]   r_feat;
  logic [CLASS_W-1:0]         r_out_class;
  logic                       r_out_err;
  logic [CNT_W-1:0]           r_cnt;

  logic w_acc, w_full, w_done, w_ohs, w_illegal;

  assign w_acc     = in_valid && (r_state == ST_LOAD);
  assign w_full    = (r_idx == IDX_W'(N_FEAT-1));
  assign w_done    = w_acc && (in_last || w_full);
  assign w_ohs     = (r_state == ST_OUT) && out_ready;
  assign w_illegal = ({1'b0, tree_class} >= LP_N_CLASS);

  assign in_ready   = (r_state == ST_LOAD);
  assign out_valid  = (r_state == ST_OUT);
  assign feat_bus   = r_feat;
  assign out_class  = r_out_class;
  assign out_err    = r_out_err;
  assign sample_cnt = r_cnt;
  assign dbg_state  = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_LOAD;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_LOAD: if (w_done) w_next = ST_EVAL;
      ST_EVAL: if (r_wait == 8'd0) w_next = ST_OUT;
      ST_OUT:  if (out_ready) w_next = ST_LOAD;
      default: w_next = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= '0;
      r_wait      <= '0;
      r_err       <= 1'b0;
      r_feat      <= '0;
      r_out_class <= '0;
      r_out_err   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (w_acc) begin
        r_feat[r_idx*FEAT_W +: FEAT_W] <= in_data;
        // An early in_last clears the tail so stale features never reach the tree.
        for (int k = 0; k < N_FEAT; k++) begin
          if (in_last && (k > int'(r_idx))) r_feat[k*FEAT_W +: FEAT_W] <= '0;
        end
        r_idx <= w_done ? '0 : r_idx + 1'b1;
        if (w_done) begin
          r_err  <= !(in_last && w_full);
          r_wait <= 8'(TREE_LAT);
        end
      end
      if (r_state == ST_EVAL) begin
        if (r_wait == 8'd0) begin
          r_out_class <= tree_class;
          r_out_err   <= r_err || w_illegal;
        end else begin
          r_wait <= r_wait - 8'd1;
        end
      end
      if (w_ohs) r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef DTREE_CLASS_HIST_EN
  logic [CNT_W-1:0] r_hist [N_CLASS];
  logic [CNT_W-1:0] r_hist_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < N_CLASS; c++) r_hist[c] <= '0;
      r_hist_rd <= '0;
    end else begin
      // Only clean results are counted; errored ones may carry an out-of-range class.
      for (int c = 0; c < N_CLASS; c++) begin
        if (w_ohs && !r_out_err && (r_out_class == CLASS_W'(c)) && (r_hist[c] != '1))
          r_hist[c] <= r_hist[c] + 1'b1;
      end
      r_hist_rd <= '0;
      for (int c = 0; c < N_CLASS; c++) begin
        if (hist_idx == CLASS_W'(c)) r_hist_rd <= r_hist[c];
      end
    end
  end

  assign hist_cnt = r_hist_rd;
`endif

endmodule

// File: tb/tb_dtree_stream_wrapper.sv
// Bench for dtree_stream_wrapper: directed framing cases plus randomized vectors against a
// feature-array reference model with an expected-result queue.
`timescale 1ns/1ps
module tb_dtree_stream_wrapper;

  localparam int N_FEAT   = 36;
  localparam int FEAT_W   = 8;
  localparam int CLASS_W  = 5;
  localparam int N_CLASS  = 16;
  localparam int TREE_LAT = 3;
  localparam int CNT_W    = 16;
  localparam int BUS_W    = N_FEAT*FEAT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                 in_valid, in_ready, in_last, out_valid, out_ready, out_err;
  logic [FEAT_W-1:0]    in_data;
  logic [BUS_W-1:0]     feat_bus;
  logic [CLASS_W-1:0]   tree_class, out_class;
  logic [CNT_W-1:0]     sample_cnt;
  logic [1:0]           dbg_state;
`ifdef DTREE_CLASS_HIST_EN
  logic [CLASS_W-1:0]   hist_idx;
  logic [CNT_W-1:0]     hist_cnt;
`endif

  dtree_stream_wrapper #(
    .N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .CLASS_W(CLASS_W),
    .N_CLASS(N_CLASS), .TREE_LAT(TREE_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .feat_bus(feat_bus), .tree_class(tree_class),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class), .out_err(out_err),
    .sample_cnt(sample_cnt), .dbg_state(dbg_state)
`ifdef DTREE_CLASS_HIST_EN
    , .hist_idx(hist_idx), .hist_cnt(hist_cnt)
`endif
  );

  // Stand-in tree: class = (feature0 + feature35) mod 2^CLASS_W.
  logic [FEAT_W:0] tree_sum;
  assign tree_sum   = {1'b0, feat_bus[0 +: FEAT_W]} + {1'b0, feat_bus[(N_FEAT-1)*FEAT_W +: FEAT_W]};
  assign tree_class = tree_sum[CLASS_W-1:0];

  // ---------------- reference model / scoreboard ----------------
  logic [FEAT_W-1:0]  m_feat [N_FEAT];
  int                 m_cnt;
  int                 m_hist [N_CLASS];
  logic [CLASS_W:0]   exp_q [$];     // {err, class}
  int                 n_checks = 0;
  int                 n_pass   = 0;

  task automatic check_val(input string tag, input logic [BUS_W-1:0] obs, input logic [BUS_W-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [BUS_W-1:0] model_bus();
    logic [BUS_W-1:0] b;
    for (int k = 0; k < N_FEAT; k++) b[k*FEAT_W +: FEAT_W] = m_feat[k];
    return b;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N_FEAT; k++) m_feat[k] = '0;
    for (int c = 0; c < N_CLASS; c++) m_hist[c] = 0;
    m_cnt = 0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [FEAT_W-1:0] d, input logic last, output int t_acc);
    int g;
    g = 0;
    if ($urandom_range(0, 3) == 0) @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = last;
    while (in_ready !== 1'b1 && g < 100) begin @(negedge clk); g++; end
    if (g >= 100) check_val("in_ready_timeout", 0, 1);
    @(negedge clk);
    t_acc = cyc;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // pat: 0 random, 1 counting 1..n, 2 all 8'hFF. last_pos < 0 means no in_last at all.
  task automatic send_vector(input int n_words, input int last_pos, input int pat, output int t_acc);
    logic [FEAT_W-1:0] d;
    logic              ferr;
    int                s;
    for (int i = 0; i < n_words; i++) begin
      d = (pat == 1) ? FEAT_W'(i + 1) : (pat == 2) ? '1 : FEAT_W'($urandom_range(0, 255));
      m_feat[i] = d;
      if (i == last_pos) for (int k = i + 1; k < N_FEAT; k++) m_feat[k] = '0;
      send_word(d, (i == last_pos), t_acc);
    end
    ferr = (last_pos != N_FEAT - 1);
    s = (int'(m_feat[0]) + int'(m_feat[N_FEAT-1])) % (1 << CLASS_W);
    exp_q.push_back({ferr || (s >= N_CLASS), CLASS_W'(s)});
  endtask

  task automatic collect(input int t_acc, input int hold);
    int               g;
    logic [CLASS_W:0] e;
    logic             stable;
    g = 0;
    check_val("in_ready_busy", in_ready, 0);
    while (out_valid !== 1'b1 && g < 300) begin @(negedge clk); g++; end
    if (g >= 300) begin check_val("out_valid_timeout", 0, 1); return; end
    check_val("latency", cyc - t_acc, TREE_LAT + 1);
    check_val("feat_bus", feat_bus, model_bus());
    e = exp_q.pop_front();
    check_val("out_class", out_class, e[CLASS_W-1:0]);
    check_val("out_err", out_err, e[CLASS_W]);
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || {out_err, out_class} !== e || in_ready !== 1'b0 ||
          sample_cnt !== CNT_W'(m_cnt)) stable = 1'b0;
    end
    check_val("hold_stable", stable, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    m_cnt++;
    if (!e[CLASS_W] && m_hist[e[CLASS_W-1:0]] < (1 << CNT_W) - 1) m_hist[e[CLASS_W-1:0]]++;
    check_val("out_valid_drop", out_valid, 0);
    check_val("sample_cnt", sample_cnt, CNT_W'(m_cnt));
    check_val("in_ready_back", in_ready, 1);
  endtask

  task automatic check_idle_zero(input string tag);
    check_val({tag, "_feat_bus"}, feat_bus, 0);
    check_val({tag, "_out_valid"}, out_valid, 0);
    check_val({tag, "_out_class"}, out_class, 0);
    check_val({tag, "_out_err"}, out_err, 0);
    check_val({tag, "_sample_cnt"}, sample_cnt, 0);
    check_val({tag, "_state"}, dbg_state, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t, mode, lp;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
`ifdef DTREE_CLASS_HIST_EN
    hist_idx = '0;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("reset");
    check_val("reset_in_ready", in_ready, 1);

    // Counting vector, legal class 37 mod 32 = 5.
    send_vector(N_FEAT, N_FEAT - 1, 1, t);
    collect(t, 0);
    // Early in_last on word 10: tail zeroed, framing error.
    send_vector(10, 9, 2, t);
    collect(t, 2);
    // No in_last at all, then a clean vector.
    send_vector(N_FEAT, -1, 0, t);
    collect(t, 1);
    send_vector(N_FEAT, N_FEAT - 1, 0, t);
    collect(t, 0);
    // Back-pressure on the result.
    send_vector(N_FEAT, N_FEAT - 1, 0, t);
    collect(t, 5);

    // Reset in the middle of a vector.
    for (int i = 0; i < 20; i++) send_word(FEAT_W'($urandom_range(0, 255)), 1'b0, t);
    #2 rst = 1'b1;
    #2 check_idle_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_val("midrst_in_ready", in_ready, 1);
    send_vector(N_FEAT, N_FEAT - 1, 0, t);
    collect(t, 1);

    // Randomized framing and back-pressure.
    for (int r = 0; r < 30; r++) begin
      mode = $urandom_range(0, 3);
      if (mode == 1) begin
        lp = $urandom_range(0, N_FEAT - 2);
        send_vector(lp + 1, lp, 0, t);
      end else if (mode == 2) begin
        send_vector(N_FEAT, -1, 0, t);
      end else begin
        send_vector(N_FEAT, N_FEAT - 1, 0, t);
      end
      collect(t, $urandom_range(0, 4));
    end

`ifdef DTREE_CLASS_HIST_EN
    for (int c = 0; c < N_CLASS; c++) begin
      hist_idx = CLASS_W'(c);
      @(negedge clk);
      check_val("hist_cnt", hist_cnt, CNT_W'(m_hist[c]));
    end
    hist_idx = CLASS_W'(N_CLASS + 4);
    @(negedge clk);
    check_val("hist_cnt_oob", hist_cnt, 0);
`endif

    check_val("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no end, expected finish");
    $fatal(1, "timeout");
  end

endmodule
